// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants for the FP result path: IEEE exception flag
//               bit positions, FP16 upper-half fill and canonical NaNs.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Bit positions inside the 5-bit {NV, OF, UF, DZ, NX} flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_OF = 3;
  localparam int FLG_UF = 2;
  localparam int FLG_DZ = 1;
  localparam int FLG_NX = 0;

  // Upper half of a 32-bit result slot when it carries an FP16 value
  localparam logic [15:0] FP16_ZERO_UPPER = 16'h0000;

  // Canonical quiet NaNs
  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [15:0] QNAN16 = 16'h7E00;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_result_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_buf_if
// Description : Producer-side and consumer-side valid/ready result streams
//               of the FP result buffer. The slave modport is the buffer's
//               view; the master modport is the surrounding pipeline's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_result_buf_if #(
  parameter int TAG_W = 5
);

  // Producer side (arithmetic units -> buffer)
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [4:0]       in_flags;
  logic             in_mode_fp;
  logic [TAG_W-1:0] in_tag;

  // Consumer side (buffer -> writeback)
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_result, in_flags, in_mode_fp, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_tag
  );

  modport master (
    output in_valid, in_result, in_flags, in_mode_fp, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_tag
  );

endinterface : fp_result_buf_if
`default_nettype wire

// File: rtl/fp_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : fp_fifo_core
// Description : Parameterized synchronous FIFO. Occupancy is tracked by an
//               explicit counter; full/empty derive from it, never from the
//               pointers. Read data is forced to zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_fifo_core #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       clear,
  input  wire logic                       wr_en,
  input  wire logic [WIDTH-1:0]           wr_data,
  input  wire logic                       rd_en,
  output logic      [WIDTH-1:0]           rd_data,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  assign count   = cnt;
  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule : fp_fifo_core
`default_nettype wire

// File: rtl/fp_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_buf
// Description : Result buffer behind the FP arithmetic units. Queues
//               {tag, flags, result} entries, zero-fills FP16 results,
//               supports flush, and accrues retiring exception flags into a
//               sticky fflags register with CSR write access.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_buf
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  fp_result_buf_if.slave              bus,
  input  wire logic                   flush,
  input  wire logic                   csr_we,
  input  wire logic [4:0]             csr_wdata,
  output logic      [4:0]             fflags,
  output logic      [$clog2(DEPTH):0] count
);

  localparam int ENTRY_W = TAG_W + 5 + 32;

  logic               enq;
  logic               deq;
  logic               full;
  logic               empty;
  logic [31:0]        stored_result;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [4:0]         fflags_next;

  // Flush overrides both handshakes so nothing moves in a flush cycle
  assign enq = bus.in_valid && bus.in_ready && !flush;
  assign deq = bus.out_valid && bus.out_ready && !flush;

  // FP16 results only own the low half; the upper half is forced to zero
  assign stored_result = bus.in_mode_fp ? bus.in_result
                                        : {FP16_ZERO_UPPER, bus.in_result[15:0]};
  assign wr_entry      = {bus.in_tag, bus.in_flags, stored_result};

  fp_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // in_ready looks only at occupancy, never at out_ready
  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_result = rd_entry[31:0];
  assign bus.out_flags  = rd_entry[36:32];
  assign bus.out_tag    = rd_entry[ENTRY_W-1:37];

  // A CSR write and a retiring entry's flags merge by OR in the same cycle
  always_comb begin
    fflags_next = csr_we ? csr_wdata : fflags;
    if (deq) begin
      fflags_next = fflags_next | bus.out_flags;
    end
  end

  // Sticky accrued-exception register
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else begin
      fflags <= fflags_next;
    end
  end

endmodule : fp_result_buf
`default_nettype wire

// File: tb/tb_fp_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_result_buf
// Description : Directed self-checking bench for fp_result_buf (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_result_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       csr_we;
  logic [4:0] csr_wdata;
  logic [4:0] fflags;
  logic [1:0] count;

  int vectors = 0;
  int miscompares = 0;

  fp_result_buf_if #(.TAG_W(5)) bus ();

  fp_result_buf #(
    .DEPTH (2),
    .TAG_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .flush     (flush),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .fflags    (fflags),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] res, input logic [4:0] flg,
                        input logic fp, input logic [4:0] tag);
    bus.in_valid   = v;
    bus.in_result  = res;
    bus.in_flags   = flg;
    bus.in_mode_fp = fp;
    bus.in_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++;
    if (bus.out_result !== 32'h0 || bus.out_flags !== 5'h0 || bus.out_tag !== 5'h0) begin
      miscompares++; $display("FAIL reset_out_zero: got %h/%b/%0d expected 0/0/0", bus.out_result, bus.out_flags, bus.out_tag);
    end
    vectors++;
    if (fflags !== 5'b0) begin miscompares++; $display("FAIL reset_fflags: got %b expected 00000", fflags); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    set_in(1'b1, 32'h40490FDB, 5'b00001, 1'b1, 5'd3);
    tick();
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h40490FDB || bus.out_tag !== 5'd3 || bus.out_flags !== 5'b00001) begin
      miscompares++; $display("FAIL basic_head: got v=%b %h tag=%0d flg=%b expected v=1 40490fdb tag=3 flg=00001",
                              bus.out_valid, bus.out_result, bus.out_tag, bus.out_flags);
    end
    vectors++;
    if (fflags !== 5'b0) begin miscompares++; $display("FAIL basic_no_accrue_on_enq: got %b expected 00000", fflags); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (fflags !== 5'b00001) begin miscompares++; $display("FAIL basic_fflags: got %b expected 00001", fflags); end
    vectors++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_drained: got count=%0d v=%b expected 0/0", count, bus.out_valid);
    end
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h11111111, 5'b0, 1'b1, 5'd1);
    tick();
    set_in(1'b1, 32'h22222222, 5'b0, 1'b1, 5'd2);
    tick();
    set_in(1'b1, 32'h33333333, 5'b0, 1'b1, 5'd3);
    vectors++;
    if (bus.in_ready !== 1'b0 || count !== 2'd2) begin
      miscompares++; $display("FAIL fill_full: got rdy=%b count=%0d expected 0/2", bus.in_ready, count);
    end
    tick();
    vectors++;
    if (count !== 2'd2 || bus.out_tag !== 5'd1) begin
      miscompares++; $display("FAIL fill_reject: got count=%0d head=%0d expected 2/1", count, bus.out_tag);
    end
    // Dequeue while full: third entry still rejected this cycle
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (count !== 2'd1 || bus.out_tag !== 5'd2 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL fill_after_deq: got count=%0d head=%0d rdy=%b expected 1/2/1", count, bus.out_tag, bus.in_ready);
    end
    tick();
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (count !== 2'd2) begin miscompares++; $display("FAIL fill_third_accept: got count=%0d expected 2", count); end
    bus.out_ready = 1'b1;
    vectors++;
    if (bus.out_tag !== 5'd2 || bus.out_result !== 32'h22222222) begin
      miscompares++; $display("FAIL fill_order_b: got tag=%0d %h expected 2 22222222", bus.out_tag, bus.out_result);
    end
    tick();
    vectors++;
    if (bus.out_tag !== 5'd3 || bus.out_result !== 32'h33333333) begin
      miscompares++; $display("FAIL fill_order_c: got tag=%0d %h expected 3 33333333", bus.out_tag, bus.out_result);
    end
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (count !== 2'd0 || fflags !== 5'b00001) begin
      miscompares++; $display("FAIL fill_end: got count=%0d fflags=%b expected 0/00001", count, fflags);
    end
  endtask

  task automatic test_fp16();
    set_in(1'b1, 32'hABCD3C00, 5'b0, 1'b0, 5'd7);
    tick();
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (bus.out_result !== 32'h00003C00) begin
      miscompares++; $display("FAIL fp16_mask: got %h expected 00003c00", bus.out_result);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_csr_collision();
    csr_we = 1'b1; csr_wdata = 5'b10000;
    tick();
    csr_we = 1'b0;
    vectors++;
    if (fflags !== 5'b10000) begin miscompares++; $display("FAIL csr_write: got %b expected 10000", fflags); end
    set_in(1'b1, 32'h7F800000, 5'b01000, 1'b1, 5'd4);
    tick();
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    csr_we = 1'b1; csr_wdata = 5'b00000;
    bus.out_ready = 1'b1;
    tick();
    csr_we = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (fflags !== 5'b01000) begin miscompares++; $display("FAIL csr_collision: got %b expected 01000", fflags); end
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'hAAAA0001, 5'b00100, 1'b1, 5'd10);
    tick();
    set_in(1'b1, 32'hAAAA0002, 5'b00010, 1'b1, 5'd11);
    tick();
    vectors++;
    if (count !== 2'd2) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 2", count); end
    set_in(1'b1, 32'hAAAA0003, 5'b10001, 1'b1, 5'd12);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin
      miscompares++; $display("FAIL flush_empty: got count=%0d v=%b res=%h expected 0/0/0", count, bus.out_valid, bus.out_result);
    end
    vectors++;
    if (fflags !== 5'b01000) begin miscompares++; $display("FAIL flush_fflags: got %b expected 01000", fflags); end
    // Flush with room available: the enqueue offered alongside it is dropped
    set_in(1'b1, 32'hBBBB0001, 5'b00001, 1'b1, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop_enq: got count=%0d v=%b expected 0/0", count, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] t;
    set_in(1'b1, 32'h0, 5'b0, 1'b1, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      t = 5'(i);
      vectors++;
      if (bus.out_tag !== t || count !== 2'd1) begin
        miscompares++; $display("FAIL wrap_order_%0d: got tag=%0d count=%0d expected %0d/1", i, bus.out_tag, count, i);
      end
      bus.out_ready = 1'b1;
      set_in(i < 9, 32'(i + 1), 5'b0, 1'b1, 5'(i + 1));
      tick();
    end
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    vectors++;
    if (count !== 2'd0) begin miscompares++; $display("FAIL wrap_end: got count=%0d expected 0", count); end
  endtask

  task automatic test_reset_midstream();
    set_in(1'b1, 32'hCAFEF00D, 5'b11111, 1'b1, 5'd20);
    tick();
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (count !== 2'd0 || fflags !== 5'b0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_midstream: got count=%0d fflags=%b v=%b expected 0/00000/0", count, fflags, bus.out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    csr_we = 1'b0;
    csr_wdata = 5'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 5'b0, 1'b1, 5'd0);
    test_reset();
    test_basic();
    test_fill();
    test_fp16();
    test_csr_collision();
    test_flush();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fp_result_buf
`default_nettype wire
